// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder datapath: default width, receiver states, counter sizing.
package bsa_pkg;

    localparam int unsigned WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Counter width for a WIDTH-bit frame; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_sum_receiver_if.sv
// Serial sum stream in, framed parallel result out, plus status and error-clear.
interface serial_sum_receiver_if #(
    parameter int unsigned WIDTH = bsa_pkg::WIDTH
) ();

    logic             frame_start;
    logic             bit_in;
    logic             bit_valid;
    logic             carry_in;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             result_valid;
    logic             result_ready;
    logic             busy;
    logic             overrun;
    logic             frame_err;
    logic             clear_err;

    modport slave (
        input  frame_start, bit_in, bit_valid, carry_in, result_ready, clear_err,
        output result, carry_out, result_valid, busy, overrun, frame_err
    );

    modport master (
        output frame_start, bit_in, bit_valid, carry_in, result_ready, clear_err,
        input  result, carry_out, result_valid, busy, overrun, frame_err
    );

endinterface

// File: rtl/sipo_core.sv
// LSB-first serial-in/parallel-out shift register with frame bit counter.
// done_c pulses on the accept that completes a frame; word_c is the word that accept produces.
module sipo_core
    import bsa_pkg::*;
#(
    parameter int unsigned WIDTH = bsa_pkg::WIDTH,
    parameter int unsigned CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept_i,
    input  logic             restart_i,
    input  logic             bit_i,
    output logic             done_c,
    output logic [WIDTH-1:0] word_c
);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    generate
        if (WIDTH > 1) begin : g_wide
            assign word_c = {bit_i, shreg_q[WIDTH-1:1]};
        end else begin : g_single
            assign word_c = bit_i;
        end
    endgenerate

    // A restart counts as bit 0 and overrides last-bit completion.
    always_comb begin
        cnt_d   = cnt_q;
        done_c  = 1'b0;
        shreg_d = shreg_q;
        if (accept_i) begin
            shreg_d = word_c;
        end
        if (restart_i) begin
            cnt_d  = (WIDTH == 1) ? CNT_W'(0) : CNT_W'(1);
            done_c = (WIDTH == 1);
        end else if (accept_i) begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                cnt_d  = CNT_W'(0);
                done_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_sum_receiver.sv
// Frames the LSB-first sum stream from the bit-serial adder into a parallel word plus carry,
// held in a one-deep output buffer behind a valid/ready handshake.
module serial_sum_receiver
    import bsa_pkg::*;
#(
    parameter int unsigned WIDTH = bsa_pkg::WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_sum_receiver_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;
    logic             busy_q;
    logic             overrun_q, overrun_d;
    logic             ferr_q, ferr_d;

    logic             start_c;
    logic             accept_c;
    logic             consume_c;
    logic             done_c;
    logic [WIDTH-1:0] word_c;

    assign start_c   = bus.bit_valid & bus.frame_start;
    assign accept_c  = bus.bit_valid & ((state_q == SHIFT) | bus.frame_start);
    assign consume_c = valid_q & bus.result_ready;

    sipo_core #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .clk       (clk),
        .rst_n     (reset),
        .accept_i  (accept_c),
        .restart_i (start_c),
        .bit_i     (bus.bit_in),
        .done_c    (done_c),
        .word_c    (word_c)
    );

    // Next state, output buffer and stickies; a set event beats clear_err.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        carry_d   = carry_q;
        valid_d   = valid_q;
        overrun_d = overrun_q & ~bus.clear_err;
        ferr_d    = ferr_q & ~bus.clear_err;

        if (start_c) begin
            state_d = (WIDTH == 1) ? IDLE : SHIFT;
            if (state_q == SHIFT) begin
                ferr_d = 1'b1;
            end
        end else if (done_c) begin
            state_d = IDLE;
        end

        if (consume_c) begin
            valid_d = 1'b0;
        end

        if (done_c) begin
            if (!valid_q || consume_c) begin
                result_d = word_c;
                carry_d  = bus.carry_in;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            result_q  <= '0;
            carry_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            valid_q   <= valid_d;
            busy_q    <= (state_d == SHIFT);
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.carry_out    = carry_q;
    assign bus.result_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;
    assign bus.frame_err    = ferr_q;

endmodule

// File: tb/tb_serial_sum_receiver.sv
// Bench for serial_sum_receiver: directed frames, expected words queued at drive time
// and compared whenever the consumer takes a result.
module tb_serial_sum_receiver;
    import bsa_pkg::*;

    logic clk;
    logic reset;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [WIDTH:0] sb[$];

    serial_sum_receiver_if #(.WIDTH(WIDTH)) bus ();

    serial_sum_receiver #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] w, input logic c,
                             input int first, input int last, input logic ready_last);
        for (int i = first; i <= last; i++) begin
            bus.bit_valid   = 1'b1;
            bus.frame_start = (i == 0);
            bus.bit_in      = w[i];
            bus.carry_in    = (i == WIDTH - 1) ? c : 1'b0;
            if (i == last && ready_last) bus.result_ready = 1'b1;
            step();
        end
        bus.bit_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.carry_in    = 1'b0;
        bus.bit_in      = 1'b0;
    endtask

    task automatic stall(input int n);
        bus.bit_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] w, input logic c);
        sb.push_back({c, w});
    endtask

    // Consumer side: a transfer happens at the next edge when valid and ready are both high.
    always @(negedge clk) begin
        if (reset && bus.result_valid && bus.result_ready) begin
            check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                logic [WIDTH:0] e;
                e = sb.pop_front();
                check_eq("sb_result", 32'(bus.result), 32'(e[WIDTH-1:0]));
                check_eq("sb_carry", 32'(bus.carry_out), 32'(e[WIDTH]));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_result"},  32'(bus.result), 32'd0);
        check_eq({tag, "_carry"},   32'(bus.carry_out), 32'd0);
        check_eq({tag, "_valid"},   32'(bus.result_valid), 32'd0);
        check_eq({tag, "_busy"},    32'(bus.busy), 32'd0);
        check_eq({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
        check_eq({tag, "_ferr"},    32'(bus.frame_err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b0;
        bus.frame_start  = 1'b0;
        bus.bit_in       = 1'b0;
        bus.bit_valid    = 1'b0;
        bus.carry_in     = 1'b0;
        bus.result_ready = 1'b0;
        bus.clear_err    = 1'b0;
        #12;
        check_all_zero("reset");
        reset = 1'b1;
        step();

        // 123+32 = 155, back-to-back bits
        push_exp(8'd155, 1'b0);
        send_bits(8'd155, 1'b0, 0, 0, 1'b0);
        check_eq("t1_busy_mid", 32'(bus.busy), 32'd1);
        check_eq("t1_valid_mid", 32'(bus.result_valid), 32'd0);
        send_bits(8'd155, 1'b0, 1, 7, 1'b0);
        check_eq("t1_valid", 32'(bus.result_valid), 32'd1);
        check_eq("t1_result", 32'(bus.result), 32'd155);
        check_eq("t1_carry", 32'(bus.carry_out), 32'd0);
        check_eq("t1_busy", 32'(bus.busy), 32'd0);
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        check_eq("t1_valid_drop", 32'(bus.result_valid), 32'd0);

        // 200+100 = 44 carry 1, with stalls
        push_exp(8'd44, 1'b1);
        send_bits(8'd44, 1'b1, 0, 2, 1'b0);
        stall(2);
        check_eq("t2_busy_stall", 32'(bus.busy), 32'd1);
        check_eq("t2_valid_stall", 32'(bus.result_valid), 32'd0);
        send_bits(8'd44, 1'b1, 3, 5, 1'b0);
        stall(2);
        check_eq("t2_valid_stall2", 32'(bus.result_valid), 32'd0);
        send_bits(8'd44, 1'b1, 6, 7, 1'b0);
        check_eq("t2_valid", 32'(bus.result_valid), 32'd1);
        check_eq("t2_result", 32'(bus.result), 32'd44);
        check_eq("t2_carry", 32'(bus.carry_out), 32'd1);
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;

        // Overrun: 15 held, 22 dropped
        push_exp(8'd15, 1'b0);
        send_bits(8'd15, 1'b0, 0, 7, 1'b0);
        send_bits(8'd22, 1'b0, 0, 7, 1'b0);
        check_eq("t3_overrun", 32'(bus.overrun), 32'd1);
        check_eq("t3_valid", 32'(bus.result_valid), 32'd1);
        check_eq("t3_result_kept", 32'(bus.result), 32'd15);
        bus.result_ready = 1'b1;
        bus.clear_err    = 1'b1;
        step();
        bus.result_ready = 1'b0;
        bus.clear_err    = 1'b0;
        check_eq("t3_valid_drop", 32'(bus.result_valid), 32'd0);
        check_eq("t3_overrun_clr", 32'(bus.overrun), 32'd0);

        // Same-edge consume and load
        push_exp(8'd15, 1'b0);
        send_bits(8'd15, 1'b0, 0, 7, 1'b0);
        push_exp(8'd22, 1'b0);
        send_bits(8'd22, 1'b0, 0, 7, 1'b1);
        check_eq("t4_valid", 32'(bus.result_valid), 32'd1);
        check_eq("t4_result", 32'(bus.result), 32'd22);
        check_eq("t4_overrun", 32'(bus.overrun), 32'd0);
        step();
        bus.result_ready = 1'b0;
        check_eq("t4_valid_drop", 32'(bus.result_valid), 32'd0);

        // Mid-frame restart, coinciding with clear_err
        send_bits(8'hA5, 1'b0, 0, 4, 1'b0);
        check_eq("t5_ferr_pre", 32'(bus.frame_err), 32'd0);
        bus.clear_err = 1'b1;
        send_bits(8'd155, 1'b0, 0, 0, 1'b0);
        bus.clear_err = 1'b0;
        check_eq("t5_ferr_set", 32'(bus.frame_err), 32'd1);
        check_eq("t5_busy", 32'(bus.busy), 32'd1);
        send_bits(8'd155, 1'b0, 1, 6, 1'b0);
        check_eq("t5_valid_early", 32'(bus.result_valid), 32'd0);
        push_exp(8'd155, 1'b0);
        send_bits(8'd155, 1'b0, 7, 7, 1'b0);
        check_eq("t5_valid", 32'(bus.result_valid), 32'd1);
        check_eq("t5_result", 32'(bus.result), 32'd155);
        check_eq("t5_ferr_sticky", 32'(bus.frame_err), 32'd1);
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        bus.clear_err    = 1'b1;
        step();
        bus.clear_err    = 1'b0;
        check_eq("t5_ferr_clr", 32'(bus.frame_err), 32'd0);

        // Async reset with a pending result and a partial frame
        send_bits(8'd15, 1'b0, 0, 7, 1'b0);
        check_eq("t6_pending", 32'(bus.result_valid), 32'd1);
        send_bits(8'd44, 1'b1, 0, 2, 1'b0);
        send_bits(8'd44, 1'b1, 0, 0, 1'b0);
        check_eq("t6_ferr_pre", 32'(bus.frame_err), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("t6_async");
        #13;
        reset = 1'b1;
        step();
        check_eq("t6_valid_post", 32'(bus.result_valid), 32'd0);
        check_eq("t6_busy_post", 32'(bus.busy), 32'd0);
        push_exp(8'd44, 1'b1);
        send_bits(8'd44, 1'b1, 0, 7, 1'b0);
        check_eq("t6_valid", 32'(bus.result_valid), 32'd1);
        check_eq("t6_result", 32'(bus.result), 32'd44);
        check_eq("t6_carry", 32'(bus.carry_out), 32'd1);
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        step();

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
